// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demultiplexer: one-hot route code steers each word into a
// per-port one-entry register; illegal codes are sunk and counted. Optional per-port
// transfer counters are enabled with `define DEMUX2_STREAM_STATS_EN.
module demux2_stream #(
  parameter int WIDTH = 2,
  parameter int ERR_W = 8
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [WIDTH-1:0] I,
  input  logic [1:0]       code,
  input  logic             I_valid,
  output logic             I_ready,
  output logic [WIDTH-1:0] O0,
  output logic             O0_valid,
  input  logic             O0_ready,
  output logic [WIDTH-1:0] O1,
  output logic             O1_valid,
  input  logic             O1_ready,
  output logic [ERR_W-1:0] err_count
`ifdef DEMUX2_STREAM_STATS_EN
  ,
  output logic [ERR_W-1:0] cnt0,
  output logic [ERR_W-1:0] cnt1
`endif
);

  localparam logic [1:0] CODE_P0 = 2'h1;
  localparam logic [1:0] CODE_P1 = 2'h2;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
  endfunction

  logic [WIDTH-1:0] o0_data_q, o0_data_d;
  logic [WIDTH-1:0] o1_data_q, o1_data_d;
  logic             o0_vld_q, o0_vld_d;
  logic             o1_vld_q, o1_vld_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic sel0, sel1, xfer, load0, load1, drain0, drain1;

  always_comb begin
    sel0 = (code == CODE_P0);
    sel1 = (code == CODE_P1);
    // Ready is a function of code and port state only, never of I_valid.
    if (sel0)      I_ready = !o0_vld_q || O0_ready;
    else if (sel1) I_ready = !o1_vld_q || O1_ready;
    else           I_ready = 1'b1;

    xfer   = I_valid && I_ready;
    load0  = xfer && sel0;
    load1  = xfer && sel1;
    drain0 = o0_vld_q && O0_ready;
    drain1 = o1_vld_q && O1_ready;

    o0_data_d = load0 ? I : o0_data_q;
    o1_data_d = load1 ? I : o1_data_q;
    o0_vld_d  = load0 ? 1'b1 : (drain0 ? 1'b0 : o0_vld_q);
    o1_vld_d  = load1 ? 1'b1 : (drain1 ? 1'b0 : o1_vld_q);
    err_d     = (xfer && !sel0 && !sel1) ? sat_inc(err_q) : err_q;
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      o0_data_q <= '0;
      o1_data_q <= '0;
      o0_vld_q  <= 1'b0;
      o1_vld_q  <= 1'b0;
      err_q     <= '0;
    end else begin
      o0_data_q <= o0_data_d;
      o1_data_q <= o1_data_d;
      o0_vld_q  <= o0_vld_d;
      o1_vld_q  <= o1_vld_d;
      err_q     <= err_d;
    end
  end

  assign O0        = o0_data_q;
  assign O1        = o1_data_q;
  assign O0_valid  = o0_vld_q;
  assign O1_valid  = o1_vld_q;
  assign err_count = err_q;

`ifdef DEMUX2_STREAM_STATS_EN
  logic [ERR_W-1:0] cnt0_q, cnt0_d;
  logic [ERR_W-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = drain0 ? sat_inc(cnt0_q) : cnt0_q;
    cnt1_d = drain1 ? sat_inc(cnt1_q) : cnt1_q;
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule
